sys_coprocessor: RTL and testbench
==================================

# sys_coprocessor

System coprocessor that responds to the core's MCR/MRC coprocessor transfers. The controller issues a request over a valid/ready handshake and the block answers over a valid/ready response channel. It holds eight 32-bit coprocessor registers: ID, control, a free-running cycle counter, a timer compare, interrupt status, and three scratch registers. It raises `irq` to the core's SVC/interrupt path on a timer match.

## Interface
- `LAT`, default 1: extra wait cycles between request accept and response (0..15).
- `ID_VALUE`, default 32'h0C0P_0001 replaced by 32'h0C0A0001: constant returned by c0.
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: core presents a transfer.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_write` in 1: 1 = MCR (core→cop write), 0 = MRC (cop→core read).
- `req_crn` in 4: register index.
- `req_wdata` in 32: MCR data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: core consumes response.
- `rsp_rdata` out 32: MRC data; 0 for writes and errors.
- `rsp_err` out 1: illegal index or write to read-only register.
- `irq` out 1: timer interrupt request, level.
- `irq_ack` in 1: clears pending timer interrupt.

## Operation
- Registers:
  - c0 ID, RO.
  - c1 CTRL: bit0 count enable, bit1 timer enable, bit2 irq enable. Other bits read 0.
  - c2 CYCLE, RW.
  - c3 CMP, RW.
  - c4 STATUS: bit0 pending, write-1-to-clear.
  - c5–c7 scratch, RW.
  - crn 8–15: error.
- FSM states:
  - IDLE: `req_ready`=1. On `req_valid`, go to WAIT if `LAT`>0, otherwise RESP.
  - WAIT: count `LAT` cycles, then go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- Accept edge (`req_valid`&`req_ready`):
  - MCR writes commit on this edge.
  - MRC data and `rsp_err` are captured into response registers on this edge.
  - Response fields stay stable until the response handshake.
- Errors:
  - Write to c0 or crn≥8 → `rsp_err`=1, no state change.
  - Read of crn≥8 → `rsp_err`=1, `rsp_rdata`=0.
- CYCLE increments by 1 each cycle while CTRL.bit0=1 and wraps FFFF_FFFF→0. An MCR to c2 on the same edge wins over the increment.
- Timer match: when CTRL.bit1=1 and CYCLE==CMP (pre-increment value), set STATUS.bit0.
- Clearing STATUS.bit0:
  - A W1C write to bit0 or `irq_ack` clears it.
  - A match on the same edge wins: bit0 stays 1.
- `irq` = STATUS.bit0 & CTRL.bit2, registered.
- `rsp_valid` held while `rsp_ready`=0. No new request is accepted until the response handshake completes.

## Timing
- Reset values:
  - `req_ready`=1 on the first cycle after reset.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `irq`=0.
  - CTRL=0, CYCLE=0, CMP=0, STATUS=0, scratch=0. State=IDLE.
- Latency: accept at the edge ending cycle N → `rsp_valid` high in cycle N+1+`LAT`.
- Throughput: one transfer per 2+`LAT` cycles with `rsp_ready` tied high.
- `irq` rises one cycle after STATUS.bit0 sets.
- Reset asserted mid-transfer aborts it: any pending response is dropped and no write commits after the reset edge.

## Configuration
- `COP_TIMER_EN` defined: CYCLE, CMP, STATUS and `irq` are implemented as specified.
- `COP_TIMER_EN` undefined:
  - c2/c3/c4 read 0, and writes to them complete without error and are ignored.
  - CTRL bits 0–1 read 0.
  - `irq` is tied 0 and `irq_ack` is ignored.
  - Handshake and scratch behaviour are unchanged.

## Structure
- Shared package `cop_pkg`:
  - register index constants (COP_ID..COP_SCR2)
  - CTRL bit positions
  - FSM state encoding (IDLE/WAIT/RESP)
  - default ID value
- Sub-module `cop_timer`: CYCLE counter, CMP register, match detect and pending/W1C/ack logic. Instantiated only under `COP_TIMER_EN`.
- The top level holds the handshake FSM, the LAT counter, register decode and scratch registers.

## Test plan
- Reset, then MRC c0 with `LAT`=1 → `rsp_valid` in cycle accept+2, `rsp_rdata`=32'h0C0A0001, `rsp_err`=0.
- MCR c5=32'hDEADBEEF, then MRC c5 with `rsp_ready` held low for 3 cycles → `rsp_valid` and data stable throughout, `req_ready`=0 until consumed, readback DEADBEEF.
- MCR c0 and MRC c9 → both `rsp_err`=1, c9 `rsp_rdata`=0, ID unchanged.
- Cycle counter: CMP=20, CTRL=3'b111, CYCLE=0.
  - STATUS.bit0 sets on the match edge, `irq`=1 one cycle later.
  - W1C STATUS=1 → `irq` falls.
  - W1C coinciding with a match → pending remains 1.
- CYCLE=FFFF_FFFE with count enable → reads wrap to 0 after 2 cycles. MCR c2 colliding with an increment → written value wins.
- Assert `reset` during WAIT of an MCR to c6 → no response, c6=0, `req_ready`=1 on the first cycle after reset.

Source files
------------

// File: rtl/cop_pkg.sv
// cop_pkg: shared definitions for the system coprocessor.
//   - Coprocessor register indices (COP_ID .. COP_SCR2)
//   - CTRL bit positions
//   - Handshake FSM state encoding
//   - Default ID value returned by c0
//   - Small decode helpers shared by the register file
package cop_pkg;

  localparam logic [3:0] COP_ID     = 4'd0;
  localparam logic [3:0] COP_CTRL   = 4'd1;
  localparam logic [3:0] COP_CYCLE  = 4'd2;
  localparam logic [3:0] COP_CMP    = 4'd3;
  localparam logic [3:0] COP_STATUS = 4'd4;
  localparam logic [3:0] COP_SCR0   = 4'd5;
  localparam logic [3:0] COP_SCR1   = 4'd6;
  localparam logic [3:0] COP_SCR2   = 4'd7;

  localparam int CTRL_CNT_EN = 0;
  localparam int CTRL_TMR_EN = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam logic [31:0] COP_ID_DEFAULT = 32'h0C0A_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } cop_state_e;

  // Indices 8..15 do not exist.
  function automatic logic cop_illegal_idx(input logic [3:0] crn);
    return crn[3];
  endfunction

  // A write is rejected for a missing register or the read-only ID.
  function automatic logic cop_wr_err(input logic [3:0] crn);
    return crn[3] || (crn == COP_ID);
  endfunction

endpackage

// File: rtl/cop_timer.sv
// cop_timer: cycle counter, compare register and timer-interrupt pending bit.
//   clk, reset      : clock / synchronous active-high reset
//   cnt_en_i        : CTRL count enable (increment CYCLE every cycle)
//   tmr_en_i        : CTRL timer enable (arm CYCLE==CMP match)
//   irq_en_i        : CTRL irq enable (gates pending onto irq_o)
//   cycle_we_i      : write CYCLE with wdata_i this edge
//   cmp_we_i        : write CMP with wdata_i this edge
//   status_we_i     : write STATUS (bit0 is write-1-to-clear)
//   wdata_i         : write data
//   irq_ack_i       : clears the pending bit
//   cycle_o, cmp_o  : current CYCLE / CMP values
//   pending_o       : STATUS.bit0
//   irq_o           : registered pending & irq enable
module cop_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cnt_en_i,
  input  logic        tmr_en_i,
  input  logic        irq_en_i,
  input  logic        cycle_we_i,
  input  logic        cmp_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wdata_i,
  input  logic        irq_ack_i,
  output logic [31:0] cycle_o,
  output logic [31:0] cmp_o,
  output logic        pending_o,
  output logic        irq_o
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] cmp_q, cmp_d;
  logic        pending_q, pending_d;
  logic        irq_q;
  logic        match;
  logic        clear;

  always_comb begin
    // Match uses the pre-increment counter value.
    match = tmr_en_i && (cycle_q == cmp_q);
    clear = (status_we_i && wdata_i[0]) || irq_ack_i;

    // A software write to CYCLE wins over the increment; wrap is natural.
    cycle_d = cycle_q;
    if (cycle_we_i)    cycle_d = wdata_i;
    else if (cnt_en_i) cycle_d = cycle_q + 32'd1;

    cmp_d = cmp_we_i ? wdata_i : cmp_q;

    // A match on the same edge as a clear keeps the bit set.
    pending_d = pending_q;
    if (match)      pending_d = 1'b1;
    else if (clear) pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      cmp_q     <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cycle_q   <= cycle_d;
      cmp_q     <= cmp_d;
      pending_q <= pending_d;
      irq_q     <= pending_q && irq_en_i;
    end
  end

  assign cycle_o   = cycle_q;
  assign cmp_o     = cmp_q;
  assign pending_o = pending_q;
  assign irq_o     = irq_q;

endmodule

// File: rtl/sys_coprocessor.sv
// sys_coprocessor: MCR/MRC coprocessor register file behind a valid/ready
// request channel and a valid/ready response channel.
//   Parameters: LAT (0..15 wait cycles between accept and response),
//               ID_VALUE (constant returned by c0)
//   clk, reset            : clock / synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write             : 1 = MCR write, 0 = MRC read
//   req_crn, req_wdata    : register index and write data
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata, rsp_err    : read data (0 for writes/errors), error flag
//   irq, irq_ack          : level timer interrupt and its acknowledge
// Build option: define COP_TIMER_EN to implement CYCLE/CMP/STATUS and irq.
// Without it c2..c4 read 0 and ignore writes, CTRL bits 0-1 read 0 and irq
// is tied low.
module sys_coprocessor
  import cop_pkg::*;
#(
  parameter int          LAT      = 1,
  parameter logic [31:0] ID_VALUE = COP_ID_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_crn,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        irq,
  input  logic        irq_ack
);

  localparam logic [3:0] LAT_M1 = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

`ifdef COP_TIMER_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b100;
`endif

  cop_state_e  state_q;
  logic [3:0]  lat_cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  ctrl_q;

  logic        accept;
  logic        wr_acc;
  logic [31:0] rd_data;
  logic [31:0] scratch_rd [3];

  logic [31:0] cycle_w;
  logic [31:0] cmp_w;
  logic        pending_w;
  logic        irq_w;

  assign accept = req_valid && req_ready_q;
  assign wr_acc = accept && req_write;

  // ---------------- Scratch registers c5..c7 ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_scr
    localparam logic [3:0] IDX = COP_SCR0 + 4'(gi);
    logic [31:0] scr_q;
    always_ff @(posedge clk) begin
      if (reset)                           scr_q <= '0;
      else if (wr_acc && req_crn == IDX)   scr_q <= req_wdata;
    end
    assign scratch_rd[gi] = scr_q;
  end

  // ---------------- CTRL ----------------
  always_ff @(posedge clk) begin
    if (reset)                            ctrl_q <= '0;
    else if (wr_acc && req_crn == COP_CTRL) ctrl_q <= req_wdata[2:0] & CTRL_WMASK;
  end

  // ---------------- Timer ----------------
`ifdef COP_TIMER_EN
  cop_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .cnt_en_i    (ctrl_q[CTRL_CNT_EN]),
    .tmr_en_i    (ctrl_q[CTRL_TMR_EN]),
    .irq_en_i    (ctrl_q[CTRL_IRQ_EN]),
    .cycle_we_i  (wr_acc && req_crn == COP_CYCLE),
    .cmp_we_i    (wr_acc && req_crn == COP_CMP),
    .status_we_i (wr_acc && req_crn == COP_STATUS),
    .wdata_i     (req_wdata),
    .irq_ack_i   (irq_ack),
    .cycle_o     (cycle_w),
    .cmp_o       (cmp_w),
    .pending_o   (pending_w),
    .irq_o       (irq_w)
  );
`else
  logic unused_irq_ack;
  assign unused_irq_ack = irq_ack;
  assign cycle_w   = '0;
  assign cmp_w     = '0;
  assign pending_w = 1'b0;
  assign irq_w     = 1'b0;
`endif

  assign irq = irq_w;

  // ---------------- Read decode / response capture ----------------
  always_comb begin
    rd_data = '0;
    case (req_crn)
      COP_ID:     rd_data = ID_VALUE;
      COP_CTRL:   rd_data = {29'd0, ctrl_q};
      COP_CYCLE:  rd_data = cycle_w;
      COP_CMP:    rd_data = cmp_w;
      COP_STATUS: rd_data = {31'd0, pending_w};
      COP_SCR0:   rd_data = scratch_rd[0];
      COP_SCR1:   rd_data = scratch_rd[1];
      COP_SCR2:   rd_data = scratch_rd[2];
      default:    rd_data = '0;
    endcase

    if (req_write) begin
      rsp_rdata_d = '0;
      rsp_err_d   = cop_wr_err(req_crn);
    end else begin
      rsp_rdata_d = rd_data;
      rsp_err_d   = cop_illegal_idx(req_crn);
    end
  end

  // ---------------- Handshake FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= 1'b0;
            if (LAT > 0) begin
              state_q   <= ST_WAIT;
              lat_cnt_q <= LAT_M1;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_sys_coprocessor.sv
// Scoreboard bench for sys_coprocessor. Stimulus pushes the expected
// response when it issues a request; a monitor pops and compares on every
// response handshake. Expectations depend on whether COP_TIMER_EN is set.
module tb_sys_coprocessor;

  localparam int          LAT = 1;
  localparam logic [31:0] ID  = 32'h0C0A_0001;
`ifdef COP_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_crn;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        irq;
  logic        irq_ack;

  sys_coprocessor #(.LAT(LAT), .ID_VALUE(ID)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_crn   (req_crn),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .irq       (irq),
    .irq_ack   (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compares each response handshake against the scoreboard head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rdata=%h err=%b, expected no response", rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          $display("rsp %-10s rdata=%h err=%b (exp %h/%b)", e.name, rsp_rdata, rsp_err, e.rdata, e.err);
          chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  // Drive a request until accepted. Returns just after the accept edge.
  task automatic issue(input logic wr, input logic [3:0] crn, input logic [31:0] wd, output bit ok);
    int   t;
    logic rdy;
    t = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_crn   = crn;
    req_wdata = wd;
    do begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1;
      t++;
    end while (rdy !== 1'b1 && t < 40);
    req_valid = 1'b0;
    ok = (rdy === 1'b1);
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got req_ready=%b, expected 1", rdy);
    end
  endtask

  // Full transfer: push expectation, issue, check latency, optionally hold
  // rsp_ready low for 'hold' cycles, then wait for the handshake.
  task automatic xfer(input string name, input logic wr, input logic [3:0] crn,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr,
                      input int hold);
    exp_t e;
    int   t;
    bit   ok;
    e.rdata = erd;
    e.err   = eerr;
    e.name  = name;
    rsp_ready = (hold == 0);
    exp_q.push_back(e);
    issue(wr, crn, wd, ok);
    if (!ok) begin
      exp_q.delete();
      rsp_ready = 1'b1;
      return;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (rsp_valid !== 1'b1 && t < 40);
    chk({name, "_lat"}, t, LAT + 1);
    if (rsp_valid !== 1'b1) begin
      exp_q.delete();
      rsp_ready = 1'b1;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      chk({name, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({name, "_hold_data"}, rsp_rdata, erd);
      chk({name, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
      if (i == hold - 1) rsp_ready = 1'b1;
      else @(negedge clk);
    end
    t = 0;
    do begin
      @(posedge clk);
      #1;
      t++;
    end while (exp_q.size() != 0 && t < 40);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_drain: got %0d pending responses, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit   ok;
    int   m;
    logic hi;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_crn   = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    irq_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state on the first cycle after reset.
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_irq",       {31'd0, irq},       32'd0);
    @(posedge clk);
    #1;

    // ID read, scratch write/readback with back-pressure, errors.
    xfer("r_id",    0, 4'd0,  32'h0,         ID,           1'b0, 0);
    xfer("w_c5",    1, 4'd5,  32'hDEADBEEF,  32'h0,        1'b0, 0);
    xfer("r_c5",    0, 4'd5,  32'h0,         32'hDEADBEEF, 1'b0, 3);
    xfer("w_c7",    1, 4'd7,  32'h0BAD_F00D, 32'h0,        1'b0, 0);
    xfer("r_c7",    0, 4'd7,  32'h0,         32'h0BAD_F00D,1'b0, 0);
    xfer("r_c6",    0, 4'd6,  32'h0,         32'h0,        1'b0, 0);
    xfer("w_c0",    1, 4'd0,  32'h1234_5678, 32'h0,        1'b1, 0);
    xfer("r_c9",    0, 4'd9,  32'h0,         32'h0,        1'b1, 0);
    xfer("w_c12",   1, 4'd12, 32'hFFFF_FFFF, 32'h0,        1'b1, 0);
    xfer("r_id2",   0, 4'd0,  32'h0,         ID,           1'b0, 0);
    xfer("w_ctrl4", 1, 4'd1,  32'hFFFF_FFFC, 32'h0,        1'b0, 0);
    xfer("r_ctrl4", 0, 4'd1,  32'h0,         32'h4,        1'b0, 0);

`ifdef COP_TIMER_EN
    // Match at CYCLE==20: irq first seen 22-LAT negedges after this xfer.
    xfer("w_cmp20", 1, 4'd3, 32'd20, 32'h0, 1'b0, 0);
    xfer("w_cyc0",  1, 4'd2, 32'd0,  32'h0, 1'b0, 0);
    xfer("w_ctrl7", 1, 4'd1, 32'd7,  32'h0, 1'b0, 0);
    m = 0;
    do begin
      @(negedge clk);
      m++;
    end while (irq !== 1'b1 && m < 60);
    chk("irq_rise_cycle", m, 22 - LAT);
    @(posedge clk);
    #1;
    xfer("r_ctrl7", 0, 4'd1, 32'h0, 32'd7, 1'b0, 0);
    xfer("r_sts1",  0, 4'd4, 32'h0, 32'd1, 1'b0, 0);
    xfer("w1c",     1, 4'd4, 32'd1, 32'h0, 1'b0, 0);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    xfer("r_sts0",  0, 4'd4, 32'h0, 32'd0, 1'b0, 0);

    // Counter frozen with CYCLE==CMP: match every edge, W1C loses.
    xfer("w_ctrl6", 1, 4'd1, 32'd6,   32'h0, 1'b0, 0);
    xfer("w_cmp",   1, 4'd3, 32'd100, 32'h0, 1'b0, 0);
    xfer("w_cyc",   1, 4'd2, 32'd100, 32'h0, 1'b0, 0);
    xfer("w1c_hit", 1, 4'd4, 32'd1,   32'h0, 1'b0, 0);
    xfer("r_sts_h", 0, 4'd4, 32'h0,   32'd1, 1'b0, 0);

    // Timer off, pending held; irq_ack clears it.
    xfer("w_ctrl4b", 1, 4'd1, 32'd4, 32'h0, 1'b0, 0);
    @(negedge clk);
    chk("irq_held", {31'd0, irq}, 32'd1);
    @(posedge clk);
    #1 irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("irq_ack_fall", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    xfer("r_sts_ack", 0, 4'd4, 32'h0, 32'd0, 1'b0, 0);

    // Wrap and write-beats-increment, read LAT+1 counts after the write.
    xfer("w_ctrl1", 1, 4'd1, 32'd1,          32'h0, 1'b0, 0);
    xfer("w_cycFE", 1, 4'd2, 32'hFFFF_FFFE,  32'h0, 1'b0, 0);
    xfer("r_wrap",  0, 4'd2, 32'h0,          32'hFFFF_FFFE + 32'(LAT + 1), 1'b0, 0);
    xfer("w_cyc55", 1, 4'd2, 32'h55,         32'h0, 1'b0, 0);
    xfer("r_cyc55", 0, 4'd2, 32'h0,          32'h55 + 32'(LAT + 1), 1'b0, 0);
    xfer("w_ctrl0", 1, 4'd1, 32'd0,          32'h0, 1'b0, 0);
`else
    // Timer absent: accesses succeed, read 0; irq never asserts.
    xfer("w_cmp20", 1, 4'd3, 32'd20, 32'h0, 1'b0, 0);
    xfer("w_cyc5",  1, 4'd2, 32'd5,  32'h0, 1'b0, 0);
    xfer("w_ctrl7", 1, 4'd1, 32'd7,  32'h0, 1'b0, 0);
    xfer("r_ctrl7", 0, 4'd1, 32'h0,  32'd4, 1'b0, 0);
    xfer("r_cyc",   0, 4'd2, 32'h0,  32'h0, 1'b0, 0);
    xfer("r_cmp",   0, 4'd3, 32'h0,  32'h0, 1'b0, 0);
    xfer("w_sts",   1, 4'd4, 32'd1,  32'h0, 1'b0, 0);
    xfer("r_sts",   0, 4'd4, 32'h0,  32'h0, 1'b0, 0);
    irq_ack = 1'b1;
    hi = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (irq !== 1'b0) hi = 1'b1;
    end
    irq_ack = 1'b0;
    chk("irq_tied", {31'd0, hi}, 32'd0);
    @(posedge clk);
    #1;
`endif

    // Reset during WAIT of an MCR to c6: response dropped, state cleared.
    issue(1'b1, 4'd6, 32'h1234_5678, ok);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    xfer("r_c6_rst", 0, 4'd6, 32'h0, 32'h0, 1'b0, 0);
    xfer("r_c5_rst", 0, 4'd5, 32'h0, 32'h0, 1'b0, 0);
    xfer("r_ctrl_r", 0, 4'd1, 32'h0, 32'h0, 1'b0, 0);
    xfer("r_sts_r",  0, 4'd4, 32'h0, 32'h0, 1'b0, 0);
    chk("tmr_flag_sanity", {31'd0, irq}, 32'd0 & {31'd0, TMR});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
